bp_fe_bht_update_queue: RTL and testbench

- Buffers resolved-branch outcomes arriving from the backend and drains them, one per cycle, into the write port of the branch history table.
- Decouples bursty branch resolution from the table's single write port.
- Provides a stall input so the frontend can hold table writes, and a flush that discards pending updates on context change.
- Sits directly upstream of the history table's write interface (write valid, write index, correct bit).

---
 rtl/bp_fe_bht_update_queue.sv | 103 ++++++++++
 tb/tb_bp_fe_bht_update_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bht_update_queue.sv
`default_nettype none
// ============================================================================
//  Module      : bp_fe_bht_update_queue
//  Description : Circular FIFO that buffers resolved-branch outcomes from the
//                backend and drains one per cycle into the branch history
//                table write port. Supports stall (hold writes), flush
//                (discard pending updates) and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_fe_bht_update_queue #(
  parameter int bht_idx_width_p = 8,
  parameter int els_p           = 4,
  localparam int lg_els_lp      = $clog2(els_p),
  localparam int cnt_width_lp   = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [bht_idx_width_p-1:0] idx_i,
  input  logic                       correct_i,
  output logic                       ready_o,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [cnt_width_lp-1:0]    count_o,
  output logic                       overflow_o
);

  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  logic [lg_els_lp-1:0]    rptr;
  logic [lg_els_lp-1:0]    wptr;
  logic [cnt_width_lp-1:0] cnt;
  logic                    overflow;
  logic [bht_idx_width_p:0] mem [els_p];

  logic full;
  logic empty;
  logic enq;
  logic deq;

  // Ready and write-valid depend only on registered state plus stall/flush,
  // so there is no combinational path from the table side back to ready_o.
  always_comb begin
    full      = (cnt == full_cnt_lp);
    empty     = (cnt == '0);
    ready_o   = ~reset_i & ~full;
    w_v_o     = ~reset_i & ~empty & ~stall_i & ~flush_i;
    enq       = v_i & ready_o & ~flush_i;
    deq       = w_v_o;
    {idx_w_o, correct_o} = mem[rptr];
    count_o    = cnt;
    overflow_o = overflow;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue next cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (enq) wptr <= wptr + lg_els_lp'(1);
      if (deq) rptr <= rptr + lg_els_lp'(1);
      if (enq & ~deq)      cnt <= cnt + cnt_width_lp'(1);
      else if (deq & ~enq) cnt <= cnt - cnt_width_lp'(1);
    end
  end

  // Sticky overflow: an update offered while the queue cannot take it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow <= 1'b0;
    end else if (v_i & ~ready_o & ~flush_i) begin
      overflow <= 1'b1;
    end
  end

  // Entry storage; contents are never reset because they are only read
  // while occupancy marks them valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= {idx_i, correct_i};
  end

`ifndef SYNTHESIS
  // Structural invariants of the queue.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (cnt <= full_cnt_lp) else $error("occupancy exceeds depth");
      assert (!w_v_o || !empty) else $error("write valid while empty");
      assert (!(v_i && $isunknown(idx_i))) else $error("unknown idx_i with v_i");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_bht_update_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_fe_bht_update_queue
//  Description : Self-checking bench for bp_fe_bht_update_queue. A queue-based
//                reference model is compared against the DUT every cycle, with
//                directed scenarios pinned by literal expectations followed by
//                randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_fe_bht_update_queue;

  localparam int W   = 8;
  localparam int ELS = 4;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0;
  logic [W-1:0] idx_i = '0;
  logic         correct_i = 1'b0;
  logic         stall_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         ready_o;
  logic         w_v_o;
  logic [W-1:0] idx_w_o;
  logic         correct_o;
  logic [2:0]   count_o;
  logic         overflow_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // reference model state: FIFO contents as {idx, correct}, sticky overflow
  logic [W:0] q[$];
  bit         m_ovf = 1'b0;

  bp_fe_bht_update_queue #(.bht_idx_width_p(W), .els_p(ELS)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .idx_i      (idx_i),
    .correct_i  (correct_i),
    .ready_o    (ready_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .w_v_o      (w_v_o),
    .idx_w_o    (idx_w_o),
    .correct_o  (correct_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model expectations for the current cycle's inputs
  function automatic bit exp_ready();
    return !reset_i && (q.size() != ELS);
  endfunction
  function automatic bit exp_wv();
    return !reset_i && (q.size() != 0) && !stall_i && !flush_i;
  endfunction

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_o", int'(ready_o), int'(exp_ready()));
      chk("w_v_o", int'(w_v_o), int'(exp_wv()));
      chk("count_o", int'(count_o), q.size());
      chk("overflow_o", int'(overflow_o), int'(m_ovf));
      if (exp_wv()) begin
        chk("idx_w_o", int'(idx_w_o), int'(q[0][W:1]));
        chk("correct_o", int'(correct_o), int'(q[0][0]));
      end
    end
  end

  // Apply inputs for a cycle and wait to the sampling point
  task automatic drive(input bit rst, input bit v, input logic [W-1:0] idx,
                       input bit c, input bit stall, input bit flush);
    reset_i = rst; v_i = v; idx_i = idx; correct_i = c;
    stall_i = stall; flush_i = flush;
    @(negedge clk);
  endtask

  // Advance across the active edge and update the model
  task automatic commit();
    bit rdy, wv;
    @(posedge clk);
    rdy = exp_ready();
    wv  = exp_wv();
    if (reset_i) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (flush_i) begin
      q.delete();
    end else begin
      if (v_i && !rdy) m_ovf = 1'b1;
      if (wv) void'(q.pop_front());
      if (v_i && rdy) q.push_back({idx_i, correct_i});
    end
    #1;
  endtask

  task automatic step(input bit rst, input bit v, input logic [W-1:0] idx,
                      input bit c, input bit stall, input bit flush);
    drive(rst, v, idx, c, stall, flush);
    commit();
  endtask

  initial begin
    // reset
    drive(1, 0, 0, 0, 0, 0);
    commit();
    chk_en = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    chk("rst ready_o", int'(ready_o), 0);
    chk("rst w_v_o", int'(w_v_o), 0);
    chk("rst count_o", int'(count_o), 0);
    chk("rst overflow_o", int'(overflow_o), 0);
    commit();
    step(0, 0, 0, 0, 0, 0);

    // single update
    drive(0, 1, 8'h1A, 0, 0, 0);
    chk("single ready", int'(ready_o), 1);
    chk("single no bypass", int'(w_v_o), 0);
    commit();
    drive(0, 0, 0, 0, 0, 0);
    chk("single w_v", int'(w_v_o), 1);
    chk("single idx", int'(idx_w_o), 'h1A);
    chk("single correct", int'(correct_o), 0);
    chk("single count1", int'(count_o), 1);
    commit();
    drive(0, 0, 0, 0, 0, 0);
    chk("single drained", int'(w_v_o), 0);
    chk("single count0", int'(count_o), 0);
    commit();

    // fill with stall, then overflow
    for (int i = 1; i <= 4; i++) step(0, 1, W'(i), 1, 1, 0);
    drive(0, 1, 8'h77, 1, 1, 0);
    chk("fill count", int'(count_o), 4);
    chk("fill ready", int'(ready_o), 0);
    commit();
    drive(0, 0, 0, 0, 0, 0);
    chk("ovf set", int'(overflow_o), 1);
    chk("ovf count", int'(count_o), 4);
    chk("drain idx1", int'(idx_w_o), 1);
    commit();
    for (int i = 2; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("drain w_v", int'(w_v_o), 1);
      chk("drain idx", int'(idx_w_o), i);
      commit();
    end

    // streaming with wrap-around
    step(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(0, k < 10, W'(k), k[0], 0, 0);
      chk("stream count", int'(count_o), 1);
      chk("stream idx", int'(idx_w_o), k - 1);
      commit();
    end

    // full plus dequeue in the same cycle
    for (int i = 0; i < 4; i++) step(0, 1, W'(8'h40 + i), 0, 1, 0);
    drive(0, 1, 8'h55, 1, 0, 0);
    chk("fulldeq ready", int'(ready_o), 0);
    chk("fulldeq w_v", int'(w_v_o), 1);
    commit();
    drive(0, 0, 0, 0, 1, 0);
    chk("fulldeq count", int'(count_o), 3);
    chk("fulldeq ready next", int'(ready_o), 1);
    commit();

    // flush with 3 queued and an incoming update
    drive(0, 1, 8'h99, 1, 0, 1);
    chk("flush w_v", int'(w_v_o), 0);
    commit();
    drive(0, 0, 0, 0, 0, 0);
    chk("flush count", int'(count_o), 0);
    chk("flush w_v next", int'(w_v_o), 0);
    chk("flush ovf kept", int'(overflow_o), 1);
    commit();

    // reset mid-stream with 2 queued and overflow set
    step(0, 1, 8'hA0, 0, 1, 0);
    step(0, 1, 8'hA1, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("midrst ready", int'(ready_o), 0);
    chk("midrst w_v", int'(w_v_o), 0);
    commit();
    drive(0, 0, 0, 0, 0, 0);
    chk("midrst count", int'(count_o), 0);
    chk("midrst ovf", int'(overflow_o), 0);
    chk("midrst ready after", int'(ready_o), 1);
    commit();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 60,
           W'($urandom),
           1'($urandom),
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 3);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
